// File: rtl/four_bit_dadda_multiplier.sv
// Exact unsigned 4x4 multiplier: explicit Dadda reduction of the AND partial products,
// a 6-bit ripple-carry final adder, and a registered 8-bit product.

module dadda_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module dadda_full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

module four_bit_dadda_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic [7:0] out
);

  // pp[i][j] has weight 2^(i+j)
  logic [3:0] pp [4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = in1 & {4{in2[i]}};
    end
  end

  // Stage 1: reduce columns 3 and 4 to height 3
  logic s3a, c3a, s4a, c4a;
  dadda_half_adder u_s1_col3 (.a(pp[0][3]), .b(pp[1][2]), .sum(s3a), .carry(c3a));
  dadda_half_adder u_s1_col4 (.a(pp[1][3]), .b(pp[2][2]), .sum(s4a), .carry(c4a));

  // Stage 2: reduce every column to height 2
  logic s2b, c2b, s3b, c3b, s4b, c4b, s5b, c5b;
  dadda_half_adder u_s2_col2 (.a(pp[0][2]), .b(pp[1][1]), .sum(s2b), .carry(c2b));
  dadda_full_adder u_s2_col3 (.a(s3a), .b(pp[2][1]), .c(pp[3][0]), .sum(s3b), .carry(c3b));
  dadda_full_adder u_s2_col4 (.a(s4a), .b(pp[3][1]), .c(c3a), .sum(s4b), .carry(c4b));
  dadda_full_adder u_s2_col5 (.a(pp[2][3]), .b(pp[3][2]), .c(c4a), .sum(s5b), .carry(c5b));

  // Final ripple-carry adder over columns 1..6
  logic [7:0] product;
  logic [6:1] cy;
  assign product[0] = pp[0][0];
  dadda_half_adder u_cpa_col1 (
    .a(pp[0][1]), .b(pp[1][0]), .sum(product[1]), .carry(cy[1])
  );
  dadda_full_adder u_cpa_col2 (
    .a(s2b), .b(pp[2][0]), .c(cy[1]), .sum(product[2]), .carry(cy[2])
  );
  dadda_full_adder u_cpa_col3 (
    .a(s3b), .b(c2b), .c(cy[2]), .sum(product[3]), .carry(cy[3])
  );
  dadda_full_adder u_cpa_col4 (
    .a(s4b), .b(c3b), .c(cy[3]), .sum(product[4]), .carry(cy[4])
  );
  dadda_full_adder u_cpa_col5 (
    .a(s5b), .b(c4b), .c(cy[4]), .sum(product[5]), .carry(cy[5])
  );
  dadda_full_adder u_cpa_col6 (
    .a(pp[3][3]), .b(c5b), .c(cy[5]), .sum(product[6]), .carry(cy[6])
  );
  assign product[7] = cy[6];

  logic [7:0] out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 8'h00;
    end else begin
      out_q <= product;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_four_bit_dadda_multiplier.sv
// Scoreboard bench for four_bit_dadda_multiplier: expected products are queued when
// inputs are driven and compared after the capturing clock edge.

module tb_four_bit_dadda_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [7:0] out;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  four_bit_dadda_multiplier dut (
    .clk(clk),
    .rst(rst),
    .in1(in1),
    .in2(in2),
    .out(out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h)", tag, got, got, want, want);
    end
  endtask

  // Drive one input set, queue its expected result, then compare after the edge.
  task automatic cycle(input string tag, input logic r, input logic [3:0] a,
                       input logic [3:0] b);
    logic [7:0] want;
    rst = r;
    in1 = a;
    in2 = b;
    exp_q.push_back(r ? 8'h00 : ({4'h0, a} * {4'h0, b}));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      want = exp_q.pop_front();
      check_eq(tag, out, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    in1 = 4'd9;
    in2 = 4'd9;

    cycle("reset0", 1'b1, 4'd9, 4'd9);
    cycle("reset1", 1'b1, 4'd9, 4'd9);
    cycle("post_reset_9x9", 1'b0, 4'd9, 4'd9);

    // Output must hold its old value until the capturing edge.
    in1 = 4'd12;
    in2 = 4'd13;
    #2;
    check_eq("hold_before_edge", out, 8'd81);
    cycle("12x13", 1'b0, 4'd12, 4'd13);

    cycle("0x15", 1'b0, 4'd0, 4'd15);
    cycle("15x0", 1'b0, 4'd15, 4'd0);
    cycle("1x15", 1'b0, 4'd1, 4'd15);
    cycle("15x15", 1'b0, 4'd15, 4'd15);

    cycle("b2b_3x5", 1'b0, 4'd3, 4'd5);
    cycle("b2b_7x7", 1'b0, 4'd7, 4'd7);
    cycle("b2b_8x2", 1'b0, 4'd8, 4'd2);

    cycle("rst_over_15x15", 1'b1, 4'd15, 4'd15);
    cycle("after_rst_15x15", 1'b0, 4'd15, 4'd15);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        cycle("sweep", 1'b0, 4'(a), 4'(b));
      end
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/four_bit_dadda_multiplier.md
Name: four_bit_dadda_multiplier

Overview:
- Unsigned 4x4-bit multiplier built from an explicit Dadda reduction tree of half and full adders, followed by a final carry-propagate adder.
- The 8-bit product is registered on the output.
- Used as the exact baseline datapath block against which the approximate multiplier variants are compared.

Parameters:
- None. Operand width is fixed at 4 bits and product width at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in1  input  4  unsigned multiplicand.
- in2  input  4  unsigned multiplier.
- out  output 8  registered unsigned product in1*in2.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: when rst=1 at a rising clk edge, out becomes 8'h00. Reset has priority over capture. Asserting rst mid-stream discards the pending product.
- Latency:
  - At each rising edge with rst=0, out captures the product of the in1/in2 values present before that edge.
  - Latency is 1 cycle and throughput is one product per cycle.
  - No handshake; inputs are not registered.
- Arithmetic: out = in1 * in2, unsigned, exact for all 256 input pairs. Range 0..225, so out is never truncated. out[7] is the final adder carry.
- Partial products: pp[i][j] = in1[j] & in2[i], weight 2^(i+j).
  - 16 AND terms.
  - Column heights for weights 0..6 are 1,2,3,4,3,2,1.
- Dadda stage 1 (target height 3):
  - Half adder on two bits of column 3; its carry goes to column 4.
  - Half adder on two bits of column 4; its carry goes to column 5.
  - Resulting heights: 1,2,3,3,3,3,1.
- Dadda stage 2 (target height 2):
  - Half adder on column 2.
  - Full adders on columns 3, 4 and 5.
  - Each carry ripples into the next column.
  - Resulting heights: 1,2,2,2,2,2,2.
  - Reduction tree total: 3 half adders, 3 full adders.
- Final adder:
  - out[0] = pp[0][0].
  - Columns 1..6 are summed by a 6-bit ripple-carry adder built from the same HA/FA cells. Column 1 uses a HA; columns 2..6 use FAs.
  - The carry out of column 6 is out[7].
- Adder cells:
  - Half adder: sum = a^b, carry = a&b.
  - Full adder: sum = a^b^c, carry = majority(a,b,c).
  - Cells are instantiated structurally as submodules. The tree must not collapse to a behavioural '*'.
- X handling: none required. Inputs are assumed driven whenever rst=0.

Test Plan:
- Apply rst=1 for 2 cycles with in1=4'd9, in2=4'd9 -> out=8'h00 throughout. First edge after rst deasserts -> out=8'd81.
- in1=12, in2=13, one edge -> out=8'd156 (8'h9C). Check out is unchanged before the edge.
- Corner cases, one per cycle:
  - 0*15 -> 0
  - 15*0 -> 0
  - 1*15 -> 15
  - 15*15 -> 225 (8'hE1, exercises out[7])
- Back-to-back: change the inputs every cycle through 3*5, 7*7, 8*2. Outputs must be 15, 49, 16 on consecutive edges, each one cycle after its inputs.
- Assert rst while in1=15, in2=15 is being captured -> out=0 on that edge. Deassert -> out=225 next edge.
- Exhaustive sweep of all 256 (in1,in2) pairs, one per cycle. Compare against a reference product delayed 1 cycle, with zero mismatches.
